// File: rtl/gray_cnt.sv
// Registered binary/Gray counter with a flop-driven Gray pointer for clock-domain crossing.
// Define GRAY_CNT_ERR_CHK_EN to build the sticky multi-bit Gray-step checker behind err_o.
module gray_cnt #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned RST_VAL    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  dir_i,
    input  logic                  ld_i,
    input  logic [DATA_WIDTH-1:0] ld_val_i,
    output logic [DATA_WIDTH-1:0] bin_o,
    output logic [DATA_WIDTH-1:0] gray_o,
    output logic                  max_o,
    output logic                  min_o,
    output logic                  wrap_o,
    output logic                  err_o
);

    localparam logic [DATA_WIDTH-1:0] RST_BIN  = DATA_WIDTH'(RST_VAL);
    localparam logic [DATA_WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    logic [DATA_WIDTH-1:0] bin_q, gray_q;
    logic [DATA_WIDTH-1:0] bin_nxt, gray_nxt;
    logic                  wrap_q, wrap_nxt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bin_nxt  = bin_q;
        wrap_nxt = 1'b0;
        if (clr_i) begin
            bin_nxt = RST_BIN;
        end else if (ld_i) begin
            bin_nxt = ld_val_i;
        end else if (en_i) begin
            if (dir_i) begin
                bin_nxt  = bin_q + ONE;
                wrap_nxt = &bin_q;
            end else begin
                bin_nxt  = bin_q - ONE;
                wrap_nxt = ~|bin_q;
            end
        end
        // Gray is derived from the next binary value so both flops land on the same edge.
        gray_nxt = bin_nxt ^ (bin_nxt >> 1);
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= RST_BIN;
            gray_q <= RST_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_nxt;
            gray_q <= gray_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    assign bin_o  = bin_q;
    assign gray_o = gray_q;
    assign wrap_o = wrap_q;
    assign max_o  = &bin_q;
    assign min_o  = ~|bin_q;

`ifdef GRAY_CNT_ERR_CHK_EN
    logic [DATA_WIDTH-1:0] gray_prev_q;
    logic [DATA_WIDTH-1:0] gray_diff;
    logic                  multi_bit;
    logic                  chk_mask_q;
    logic                  err_q;

    // x & (x-1) is non-zero exactly when more than one bit of x is set.
    assign gray_diff = gray_q ^ gray_prev_q;
    assign multi_bit = |(gray_diff & (gray_diff - ONE));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gray_prev_q <= RST_GRAY;
            chk_mask_q  <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            gray_prev_q <= gray_q;
            chk_mask_q  <= clr_i | ld_i;
            if (clr_i) begin
                err_q <= 1'b0;
            end else if (!chk_mask_q && multi_bit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_cnt.sv
// Self-checking bench for gray_cnt (DATA_WIDTH = 4, RST_VAL = 0): directed plan steps plus
// randomized steps scored against an integer reference model of the counter.
module tb_gray_cnt;

    localparam int W = 4;
    localparam int MODULUS = 1 << W;

    logic         clk_i = 1'b0;
    logic         rst_i, clr_i, en_i, dir_i, ld_i;
    logic [W-1:0] ld_val_i;
    logic [W-1:0] bin_o, gray_o;
    logic         max_o, min_o, wrap_o, err_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: plain integer count, expected wrap pulse and error flag.
    int   m_bin  = 0;
    logic m_wrap = 1'b0;
    logic m_err  = 1'b0;

    logic [W-1:0] gray_tbl [16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                    4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    gray_cnt #(.DATA_WIDTH(W), .RST_VAL(0)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (clr_i),
        .en_i     (en_i),
        .dir_i    (dir_i),
        .ld_i     (ld_i),
        .ld_val_i (ld_val_i),
        .bin_o    (bin_o),
        .gray_o   (gray_o),
        .max_o    (max_o),
        .min_o    (min_o),
        .wrap_o   (wrap_o),
        .err_o    (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] to_gray(input int b);
        logic [W-1:0] v;
        v = W'(b);
        return v ^ (v >> 1);
    endfunction

    // Apply one set of inputs across one rising edge, advance the model, and check all outputs.
    task automatic step(input logic r, input logic c, input logic l, input logic [W-1:0] v,
                        input logic e, input logic d);
        logic [W-1:0] prev_gray;
        logic         counted;
        prev_gray = gray_o;
        counted   = !r && !c && !l && e;
        rst_i = r; clr_i = c; ld_i = l; ld_val_i = v; en_i = e; dir_i = d;
        @(posedge clk_i);
        #1;
        if (r || c) begin
            m_bin = 0; m_wrap = 1'b0; m_err = 1'b0;
        end else if (l) begin
            m_bin = int'(v); m_wrap = 1'b0;
        end else if (e) begin
            m_wrap = d ? (m_bin == MODULUS - 1) : (m_bin == 0);
            m_bin  = d ? (m_bin + 1) % MODULUS : (m_bin + MODULUS - 1) % MODULUS;
        end else begin
            m_wrap = 1'b0;
        end
        check("bin",  32'(bin_o),  32'(m_bin));
        check("gray", 32'(gray_o), 32'(to_gray(m_bin)));
        check("wrap", 32'(wrap_o), 32'(m_wrap));
        check("max",  32'(max_o),  32'(m_bin == MODULUS - 1));
        check("min",  32'(min_o),  32'(m_bin == 0));
        check("err",  32'(err_o),  32'(m_err));
        if (counted) check("gray_onebit", 32'($countones(gray_o ^ prev_gray)), 32'd1);
    endtask

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; ld_i = 1'b0; ld_val_i = '0; en_i = 1'b0; dir_i = 1'b0;

        // Reset state
        step(1, 0, 0, 4'h0, 0, 0);
        step(1, 0, 0, 4'h0, 1, 1);
        check("rst_bin",  32'(bin_o),  32'd0);
        check("rst_gray", 32'(gray_o), 32'd0);

        // Sixteen up-steps through the full Gray sequence
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 4'h0, 1, 1);
            check("up_bin_seq",  32'(bin_o),  32'((i + 1) % 16));
            check("up_gray_tbl", 32'(gray_o), 32'(gray_tbl[i]));
        end
        step(0, 0, 0, 4'h0, 0, 1);  // hold clears the wrap pulse

        // Load wins over enable, then one down-step
        step(0, 0, 1, 4'h5, 1, 1);
        check("ld_gray", 32'(gray_o), 32'h7);
        step(0, 0, 0, 4'h0, 1, 0);
        check("dn_gray", 32'(gray_o), 32'h6);

        // Down-wrap from zero
        step(0, 0, 1, 4'h0, 0, 0);
        step(0, 0, 0, 4'h0, 1, 0);
        check("dnwrap_gray", 32'(gray_o), 32'h8);
        check("dnwrap_pulse", 32'(wrap_o), 32'd1);
        step(0, 0, 0, 4'h0, 0, 0);

        // Count to 9, then reset beats enable and load
        step(0, 0, 1, 4'h6, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'h0, 1, 1);
        check("at_nine", 32'(bin_o), 32'd9);
        step(1, 0, 1, 4'hA, 1, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'h0, 1, 1);
        check("post_rst_gray", 32'(gray_o), 32'h2);

        // Clear beats load
        step(0, 1, 1, 4'hC, 1, 1);
        check("clr_bin", 32'(bin_o), 32'd0);

        // Random count/hold traffic: err must stay low
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0, 4'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Random traffic with occasional reset, clear and load
        for (int i = 0; i < 60; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 19);
            step(sel == 0, sel == 1, sel == 2 || sel == 3, 4'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

`ifdef GRAY_CNT_ERR_CHK_EN
        // Corrupt two Gray bits with the counter idle; err must latch until clear
        step(0, 0, 0, 4'h0, 0, 0);
        rst_i = 1'b0; clr_i = 1'b0; ld_i = 1'b0; en_i = 1'b0;
        force dut.gray_q = to_gray(m_bin) ^ 4'b0011;
        @(posedge clk_i);
        #1;
        release dut.gray_q;
        m_err = 1'b1;
        check("err_set", 32'(err_o), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'h0, i[0], 1);
        check("err_sticky", 32'(err_o), 32'd1);
        step(0, 1, 0, 4'h0, 0, 0);
        check("err_clr", 32'(err_o), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_cnt.md
Name: gray_cnt

Overview:
- Registered binary/Gray counter.
- Produces a glitch-free, flop-driven Gray-coded pointer. The pointer is meant to cross a clock domain and be decoded by the gray2bin converter on the far side.
- Typical use: async FIFO read/write pointers, cross-domain event counters.
- Gray and binary views are both held in registers. At most one Gray bit changes per count step.

Parameters:
- DATA_WIDTH, 4, counter width in bits; legal range 1..32.
- RST_VAL, 0, binary value loaded on reset and on clear; must be < 2**DATA_WIDTH.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous, active-high reset
- clr_i  input  1  synchronous clear to RST_VAL
- en_i  input  1  count enable, one step per cycle
- dir_i  input  1  count direction: 1 = up, 0 = down
- ld_i  input  1  synchronous load
- ld_val_i  input  DATA_WIDTH  binary value to load
- bin_o  output  DATA_WIDTH  registered binary count
- gray_o  output  DATA_WIDTH  registered Gray count, driven directly from a flop
- max_o  output  1  bin_o == all ones
- min_o  output  1  bin_o == 0
- wrap_o  output  1  single-cycle pulse after a wrap-around step
- err_o  output  1  sticky Gray-step error (only with the optional feature)

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i. No asynchronous reset.
- Priority each rising edge: rst_i > clr_i > ld_i > en_i > hold.
- Reset values:
  - bin_o = RST_VAL, gray_o = RST_VAL ^ (RST_VAL >> 1).
  - wrap_o = 0, err_o = 0.
  - max_o and min_o follow the reset value of bin_o.
- Next-value computation:
  - bin_nxt = bin_q ± 1, modulo 2**DATA_WIDTH.
  - gray_nxt = bin_nxt ^ (bin_nxt >> 1), computed from bin_nxt.
  - Both registers update on the same edge.
  - gray_o never comes from combinational logic after the flop.
- Latency: the count request is sampled at edge N; bin_o and gray_o show the new value after edge N.
- clr_i: bin = RST_VAL, Gray equivalent loaded, wrap_o = 0 that cycle. The Gray step may be multi-bit; this is allowed.
- ld_i: bin = ld_val_i, gray = ld_val_i ^ (ld_val_i >> 1), wrap_o = 0.
  - en_i is ignored in the same cycle.
  - Gray may change by more than one bit.
  - The user must only load while the far domain is quiescent.
- en_i with dir_i = 1:
  - Increment.
  - From all ones, go to 0 and assert wrap_o for exactly the next cycle.
- en_i with dir_i = 0:
  - Decrement.
  - From 0, go to all ones and assert wrap_o for the next cycle.
- en_i = 0: hold all state; wrap_o = 0.
- wrap_o is registered. It never asserts on a clr, ld or hold cycle.
- max_o and min_o:
  - Combinational decode of the bin register, so no added latency.
  - With DATA_WIDTH = 1: max_o = bin_o, min_o = ~bin_o.
- DATA_WIDTH = 1: gray_o == bin_o, and it toggles on every enabled step in either direction.
- Direction change mid-stream is allowed on any cycle and takes effect on that step.
- Reset mid-operation always restores the reset values, regardless of the other inputs.

Optional Feature:
- Macro: GRAY_CNT_ERR_CHK_EN.
- Defined:
  - Adds a registered copy of the previous gray_o.
  - Each cycle that was a pure count or hold step (no rst, clr or ld on the previous edge), the popcount of (gray_o ^ gray_prev) must be ≤ 1.
  - On a violation, err_o is set and stays set until rst_i or clr_i.
  - The check is masked for the cycle after rst_i, clr_i or ld_i.
- Not defined: err_o is tied to 0, and no extra flops or compare logic are built.

Test Plan (DATA_WIDTH = 4, RST_VAL = 0):
- Reset then en_i = 1, dir_i = 1 for 16 cycles:
  - bin_o runs 1..15, 0.
  - gray_o runs 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
  - wrap_o is high only in the cycle after 15→0.
  - Exactly one gray bit changes per step.
- ld_i = 1 with ld_val_i = 5 and en_i = 1 in the same cycle:
  - bin_o = 5, gray_o = 7, no increment, wrap_o = 0.
  - Next en_i, dir_i = 0 cycle: bin_o = 4, gray_o = 6.
- From bin_o = 0, dir_i = 0, en_i = 1:
  - bin_o = 15, gray_o = 8, wrap_o pulses once, max_o = 1, min_o = 0.
- Count to bin_o = 9, then assert rst_i together with en_i and ld_i:
  - bin_o = 0, gray_o = 0, wrap_o = 0 next cycle.
  - Then 3 count-up steps give bin_o = 3, gray_o = 2.
- clr_i and ld_i together with ld_val_i = 12: clr wins, so bin_o = 0, gray_o = 0.
- With GRAY_CNT_ERR_CHK_EN:
  - Run 100 random en_i/dir_i cycles with no ld_i: err_o must stay 0.
  - Then force a 2-bit gray flop corruption (bench force): err_o = 1 and stays 1 until clr_i.
